// File: rtl/core_mmio_arbiter_if.sv
// MMIO request/response bundle shared by requesters and the target.
// One instance per port; the target side leaves the rsp strobe unused.
interface core_mmio_arbiter_if #(
    parameter int MEM_ADDR_R = 38,
    parameter int MEM_DATA_R = 63,
    parameter int MEM_PRV_R  = 1
) ();
    logic                  req;
    logic                  wen;
    logic [MEM_ADDR_R:0]   addr;
    logic [MEM_DATA_R:0]   wdata;
    logic [MEM_PRV_R:0]    prv;
    logic                  gnt;
    logic                  rsp;
    logic [MEM_DATA_R:0]   rdata;
    logic                  error;

    modport master (
        output req, wen, addr, wdata, prv,
        input  gnt, rsp, rdata, error
    );

    modport slave (
        input  req, wen, addr, wdata, prv,
        output gnt, rsp, rdata, error
    );

    modport mmio_m (
        output req, wen, addr, wdata, prv,
        input  gnt, rdata, error
    );

    modport mmio_s (
        input  req, wen, addr, wdata, prv,
        output gnt, rdata, error
    );
endinterface

// File: rtl/core_mmio_arbiter.sv
// Two-port arbiter sharing the counter/timer MMIO target between the
// load/store unit (port 0) and the debug module (port 1).
module core_mmio_arbiter #(
    parameter int MEM_ADDR_R = 38,
    parameter int MEM_DATA_R = 63,
    parameter int MEM_PRV_R  = 1,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              g_clk,
    input  logic              g_resetn,
    core_mmio_arbiter_if.slave  rq0,
    core_mmio_arbiter_if.slave  rq1,
    core_mmio_arbiter_if.mmio_m mmio
);

    logic both;
    logic sel1;
    logic acc;

    logic rsp_pend_q;
    logic rsp_pend_d;
    logic rsp_owner_q;
    logic rsp_owner_d;
    logic rr_last_q;
    logic rr_last_d;

    // Pick the winning port; rr pointer only moves on acceptance so a
    // stalled winner keeps being presented.
    always_comb begin
        both = rq0.req & rq1.req;
        if (both) begin
            sel1 = FIXED_PRIO ? 1'b0 : ~rr_last_q;
        end else begin
            sel1 = rq1.req;
        end
    end

    // Forward the winner's payload; all-zero when nobody is asking.
    always_comb begin
        mmio.req   = (rq0.req | rq1.req) & g_resetn;
        mmio.wen   = 1'b0;
        mmio.addr  = '0;
        mmio.wdata = '0;
        mmio.prv   = '0;
        if (sel1 && rq1.req) begin
            mmio.wen   = rq1.wen;
            mmio.addr  = rq1.addr;
            mmio.wdata = rq1.wdata;
            mmio.prv   = rq1.prv;
        end else if (rq0.req) begin
            mmio.wen   = rq0.wen;
            mmio.addr  = rq0.addr;
            mmio.wdata = rq0.wdata;
            mmio.prv   = rq0.prv;
        end
    end

    assign acc = mmio.req & mmio.gnt;

    assign rq0.gnt = acc & ~sel1;
    assign rq1.gnt = acc & sel1;

    // Response data is a plain copy; only the strobes carry meaning.
    assign rq0.rsp   = g_resetn & rsp_pend_q & ~rsp_owner_q;
    assign rq1.rsp   = g_resetn & rsp_pend_q & rsp_owner_q;
    assign rq0.rdata = mmio.rdata;
    assign rq1.rdata = mmio.rdata;
    assign rq0.error = mmio.error;
    assign rq1.error = mmio.error;

    // Track the in-flight owner and update the round-robin pointer.
    always_comb begin
        rsp_pend_d  = acc;
        rsp_owner_d = rsp_owner_q;
        rr_last_d   = rr_last_q;
        if (acc) begin
            rsp_owner_d = sel1;
            if (both) begin
                rr_last_d = sel1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            rsp_pend_q  <= 1'b0;
            rsp_owner_q <= 1'b0;
            rr_last_q   <= 1'b1;
        end else begin
            rsp_pend_q  <= rsp_pend_d;
            rsp_owner_q <= rsp_owner_d;
            rr_last_q   <= rr_last_d;
        end
    end

endmodule

// File: tb/tb_core_mmio_arbiter.sv
// Directed bench for core_mmio_arbiter, round-robin and fixed-priority.
module tb_core_mmio_arbiter;

    logic g_clk = 1'b0;
    logic g_resetn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 g_clk = ~g_clk;

    core_mmio_arbiter_if r0 ();
    core_mmio_arbiter_if r1 ();
    core_mmio_arbiter_if mm ();
    core_mmio_arbiter_if f0 ();
    core_mmio_arbiter_if f1 ();
    core_mmio_arbiter_if fm ();

    core_mmio_arbiter #(.FIXED_PRIO(1'b0)) dut_rr (
        .g_clk   (g_clk),
        .g_resetn(g_resetn),
        .rq0     (r0),
        .rq1     (r1),
        .mmio    (mm)
    );

    core_mmio_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
        .g_clk   (g_clk),
        .g_resetn(g_resetn),
        .rq0     (f0),
        .rq1     (f1),
        .mmio    (fm)
    );

    assign mm.rsp = 1'b0;
    assign fm.rsp = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        r0.req = 0; r0.wen = 0; r0.addr = '0; r0.wdata = '0; r0.prv = '0;
        r1.req = 0; r1.wen = 0; r1.addr = '0; r1.wdata = '0; r1.prv = '0;
        f0.req = 0; f0.wen = 0; f0.addr = '0; f0.wdata = '0; f0.prv = '0;
        f1.req = 0; f1.wen = 0; f1.addr = '0; f1.wdata = '0; f1.prv = '0;
    endtask

    initial begin
        idle_all();
        mm.gnt = 0; mm.rdata = '0; mm.error = 0;
        fm.gnt = 1; fm.rdata = '0; fm.error = 0;

        // reset: request pending, target ready, nothing must be granted
        r0.req = 1; mm.gnt = 1;
        repeat (2) @(posedge g_clk);
        @(negedge g_clk);
        #1;
        chk("rst_gnt0", 64'(r0.gnt), 64'd0);
        chk("rst_rsp0", 64'(r0.rsp), 64'd0);
        chk("rst_rsp1", 64'(r1.rsp), 64'd1 - 64'd1);

        // single read from port 0
        @(negedge g_clk);
        g_resetn = 1; r0.req = 1; r0.addr = 39'h0; r0.prv = 2'b10;
        #1;
        chk("t1_gnt0", 64'(r0.gnt), 64'd1);
        chk("t1_gnt1", 64'(r1.gnt), 64'd0);
        chk("t1_mreq", 64'(mm.req), 64'd1);
        chk("t1_mprv", 64'(mm.prv), 64'd2);
        @(negedge g_clk);
        r0.req = 0; mm.rdata = 64'h1234;
        #1;
        chk("t1_rsp0", 64'(r0.rsp), 64'd1);
        chk("t1_rdata0", r0.rdata, 64'h1234);
        chk("t1_rsp1", 64'(r1.rsp), 64'd0);
        chk("t1_idle_addr", 64'(mm.addr), 64'd0);
        @(negedge g_clk);
        #1;
        chk("t1_rsp0_off", 64'(r0.rsp), 64'd0);

        // both requesting: strict alternation, back-to-back responses
        r0.req = 1; r0.addr = 39'h0;
        r1.req = 1; r1.addr = 39'h4;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge g_clk);
            mm.rdata = 64'hA0 + 64'(k);
            #1;
            chk("t2_gnt0", 64'(r0.gnt), 64'((k % 2) == 0));
            chk("t2_gnt1", 64'(r1.gnt), 64'((k % 2) == 1));
            chk("t2_addr", 64'(mm.addr), ((k % 2) == 0) ? 64'h0 : 64'h4);
            if (k > 0) begin
                chk("t2_rsp0", 64'(r0.rsp), 64'(((k - 1) % 2) == 0));
                chk("t2_rsp1", 64'(r1.rsp), 64'(((k - 1) % 2) == 1));
                chk("t2_rdata", ((k - 1) % 2 == 0) ? r0.rdata : r1.rdata,
                    64'hA0 + 64'(k));
            end
        end
        @(negedge g_clk);
        r0.req = 0; r1.req = 0; mm.rdata = 64'hA4;
        #1;
        chk("t2_last_rsp1", 64'(r1.rsp), 64'd1);
        chk("t2_last_rsp0", 64'(r0.rsp), 64'd0);
        chk("t2_last_rdata", r1.rdata, 64'hA4);

        // fixed priority: port 0 always wins
        f0.req = 1; f1.req = 1; f1.addr = 39'h8;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge g_clk);
            #1;
            chk("t3_gnt0", 64'(f0.gnt), 64'd1);
            chk("t3_gnt1", 64'(f1.gnt), 64'd0);
        end
        @(negedge g_clk);
        f0.req = 0;
        #1;
        chk("t3_gnt1_after", 64'(f1.gnt), 64'd1);
        chk("t3_addr_after", 64'(fm.addr), 64'h8);
        @(negedge g_clk);
        f1.req = 0;
        #1;
        chk("t3_rsp1", 64'(f1.rsp), 64'd1);

        // port 1 write stalled by target for two cycles
        @(negedge g_clk);
        mm.gnt = 0;
        r1.req = 1; r1.wen = 1; r1.addr = 39'h8; r1.wdata = 64'h100;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge g_clk);
            if (k == 2) mm.gnt = 1;
            #1;
            chk("t4_gnt1", 64'(r1.gnt), 64'(k == 2));
            chk("t4_addr", 64'(mm.addr), 64'h8);
            chk("t4_wdata", mm.wdata, 64'h100);
            chk("t4_wen", 64'(mm.wen), 64'd1);
            chk("t4_rsp1", 64'(r1.rsp), 64'd0);
        end
        @(negedge g_clk);
        r1.req = 0; r1.wen = 0; mm.error = 0;
        #1;
        chk("t4_rsp1_after", 64'(r1.rsp), 64'd1);
        chk("t4_err1", 64'(r1.error), 64'd0);

        // port 0 read to an unmapped address, target flags error
        @(negedge g_clk);
        r0.req = 1; r0.addr = 39'h40;
        #1;
        chk("t5_gnt0", 64'(r0.gnt), 64'd1);
        @(negedge g_clk);
        r0.req = 0; mm.error = 1;
        #1;
        chk("t5_rsp0", 64'(r0.rsp), 64'd1);
        chk("t5_err0", 64'(r0.error), 64'd1);
        chk("t5_rsp1", 64'(r1.rsp), 64'd0);
        @(negedge g_clk);
        mm.error = 0;

        // reset in the response cycle drops the response and rr state
        r0.req = 1; r1.req = 1; r0.addr = 39'h0; r1.addr = 39'h4;
        #1;
        chk("t6_gnt0", 64'(r0.gnt), 64'd1);
        @(negedge g_clk);
        g_resetn = 0; r0.req = 0; r1.req = 0;
        #1;
        chk("t6_rsp0_rst", 64'(r0.rsp), 64'd0);
        chk("t6_rsp1_rst", 64'(r1.rsp), 64'd0);
        @(negedge g_clk);
        g_resetn = 1;
        #1;
        chk("t6_rsp0_post", 64'(r0.rsp), 64'd0);
        chk("t6_rsp1_post", 64'(r1.rsp), 64'd0);
        @(negedge g_clk);
        r0.req = 1; r1.req = 1;
        #1;
        chk("t6_favour0", 64'(r0.gnt), 64'd1);
        chk("t6_nofav1", 64'(r1.gnt), 64'd0);
        @(negedge g_clk);
        idle_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
